// File: rtl/alu32_logic_locked.sv
// Registered 32-bit ALU with ARM-style N/Z/C/V status, logic-locked by an 8-bit key.
// A wrong key XORs a key-derived mask into the result and suppresses the carry/overflow flags.
module alu32_logic_locked #(
    parameter logic [7:0] KEY   = 8'h26,
    parameter int         WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic [7:0]       key,
    output logic [WIDTH-1:0] alu_out,
    output logic [31:0]      apsr
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_LSL  = 4'h7,
        OP_LSR  = 4'h8,
        OP_ASR  = 4'h9,
        OP_ROR  = 4'hA,
        OP_SLT  = 4'hB,
        OP_SLTU = 4'hC,
        OP_MOV  = 4'hD,
        OP_RSB  = 4'hE,
        OP_PASS = 4'hF
    } alu_op_t;

    alu_op_t          op;
    logic [SHW-1:0]   shamt;
    logic [SHW-1:0]   ror_back;
    logic             shift_nz;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH:0]   rsb_full;
    logic [WIDTH:0]   lsl_full;
    logic [WIDTH:0]   lsr_full;
    logic [WIDTH:0]   asr_full;
    logic [WIDTH-1:0] ror_res;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;

    logic [7:0]       diff;
    logic             locked;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] out_next;
    logic             n_next;
    logic             z_next;
    logic             c_next;
    logic             v_next;

    assign op       = alu_op_t'(alu_op);
    assign shamt    = b[SHW-1:0];
    assign shift_nz = (shamt != '0);
    assign ror_back = '0 - shamt;

    // The extra top bit of each sum is the carry out; subtraction adds the
    // inverted subtrahend plus one, so that carry is directly NOT borrow.
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign rsb_full = {1'b0, b} + {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};

    // One guard bit beside the operand catches the last bit shifted out.
    assign lsl_full = {1'b0, a} << shamt;
    assign lsr_full = {a, 1'b0} >> shamt;
    assign asr_full = $signed({a, 1'b0}) >>> shamt;
    assign ror_res  = (a >> shamt) | (a << ror_back);

    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (op)
            OP_ADD: begin
                res   = add_full[WIDTH-1:0];
                res_c = add_full[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sub_full[WIDTH-1:0];
                res_c = sub_full[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_RSB: begin
                res   = rsb_full[WIDTH-1:0];
                res_c = rsb_full[WIDTH];
                res_v = (b[WIDTH-1] != a[WIDTH-1]) && (res[WIDTH-1] != b[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_NOT:  res = ~a;
            OP_LSL: begin
                res   = lsl_full[WIDTH-1:0];
                res_c = shift_nz & lsl_full[WIDTH];
            end
            OP_LSR: begin
                res   = lsr_full[WIDTH:1];
                res_c = shift_nz & lsr_full[0];
            end
            OP_ASR: begin
                res   = asr_full[WIDTH:1];
                res_c = shift_nz & asr_full[0];
            end
            OP_ROR: begin
                res   = ror_res;
                res_c = shift_nz & ror_res[WIDTH-1];
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MOV:  res = b;
            OP_PASS: res = a;
            default: res = '0;
        endcase
    end

    // Locking: the mask is all-zero only for the correct key, so an unlocked
    // datapath is exact and any other key corrupts every byte identically.
    assign diff     = key ^ KEY;
    assign locked   = (diff != 8'h00);
    assign mask     = {(WIDTH / 8){diff}};
    assign out_next = res ^ mask;

    assign n_next = out_next[WIDTH-1];
    assign z_next = (out_next == '0);
    assign c_next = locked ? 1'b0 : res_c;
    assign v_next = locked ? 1'b0 : res_v;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
            apsr    <= '0;
        end else begin
            alu_out <= out_next;
            apsr    <= {n_next, z_next, c_next, v_next, 28'h0};
        end
    end

endmodule

// File: tb/tb_alu32_logic_locked.sv
// Self-checking bench for alu32_logic_locked: reset behaviour, directed vectors
// with hand-derived results, and randomized vectors against a behavioural model.
module tb_alu32_logic_locked;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [7:0]  key;
    logic [31:0] alu_out;
    logic [31:0] apsr;

    int checks;
    int failures;

    alu32_logic_locked dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .alu_op  (alu_op),
        .key     (key),
        .alu_out (alu_out),
        .apsr    (apsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic and bit-at-a-time shifting.
    function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [3:0] mop, input logic [7:0] mk);
        logic [31:0] r;
        logic [31:0] x;
        logic [31:0] o;
        logic [7:0]  d;
        logic        c;
        logic        v;
        logic        fn;
        logic        fz;
        longint      sa;
        longint      sb;
        longint      t;
        longint      ua;
        longint      ub;
        int          n;
        r  = 32'h0;
        c  = 1'b0;
        v  = 1'b0;
        t  = 0;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = longint'({32'h0, ma});
        ub = longint'({32'h0, mb});
        n  = int'(mb[4:0]);
        x  = ma;
        case (mop)
            4'h0: begin r = ma + mb; c = (ua + ub) > 64'hFFFF_FFFF; t = sa + sb; end
            4'h1: begin r = ma - mb; c = (ma >= mb); t = sa - sb; end
            4'hE: begin r = mb - ma; c = (mb >= ma); t = sb - sa; end
            4'h2: r = ma & mb;
            4'h3: r = ma | mb;
            4'h4: r = ma ^ mb;
            4'h5: r = ~(ma | mb);
            4'h6: r = ~ma;
            4'h7: begin for (int i = 0; i < n; i++) begin c = x[31]; x = x << 1; end r = x; end
            4'h8: begin for (int i = 0; i < n; i++) begin c = x[0]; x = x >> 1; end r = x; end
            4'h9: begin for (int i = 0; i < n; i++) begin c = x[0]; x = {x[31], x[31:1]}; end r = x; end
            4'hA: begin for (int i = 0; i < n; i++) begin c = x[0]; x = {x[0], x[31:1]}; end r = x; end
            4'hB: r = (sa < sb) ? 32'd1 : 32'd0;
            4'hC: r = (ma < mb) ? 32'd1 : 32'd0;
            4'hD: r = mb;
            default: r = ma;
        endcase
        if (mop == 4'h0 || mop == 4'h1 || mop == 4'hE)
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        d = mk ^ 8'h26;
        o = r ^ {d, d, d, d};
        if (d != 8'h00) begin
            c = 1'b0;
            v = 1'b0;
        end
        fn = o[31];
        fz = (o == 32'h0);
        return {o, fn, fz, c, v, 28'h0};
    endfunction

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [3:0] iop, input logic [7:0] ik);
        @(negedge clk);
        a      = ia;
        b      = ib;
        alu_op = iop;
        key    = ik;
    endtask

    task automatic run_dir(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                           input logic [3:0] iop, input logic [7:0] ik,
                           input logic [31:0] exp_out, input logic [31:0] exp_apsr);
        drive(ia, ib, iop, ik);
        @(posedge clk);
        #1;
        check({tag, "_out"}, alu_out, exp_out);
        check({tag, "_apsr"}, apsr, exp_apsr);
    endtask

    task automatic run_model(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                             input logic [3:0] iop, input logic [7:0] ik);
        logic [63:0] e;
        e = model(ia, ib, iop, ik);
        drive(ia, ib, iop, ik);
        @(posedge clk);
        #1;
        check({tag, "_out"}, alu_out, e[63:32]);
        check({tag, "_apsr"}, apsr, e[31:0]);
    endtask

    initial begin
        logic [7:0] rk;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        a        = 32'h1234_5678;
        b        = 32'h0000_0003;
        alu_op   = 4'h0;
        key      = 8'h26;

        #1;
        check("rst_t0_out", alu_out, 32'h0);
        check("rst_t0_apsr", apsr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 4'($urandom_range(0, 15)), 8'h26);
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d_out", i), alu_out, 32'h0);
            check($sformatf("rst_hold%0d_apsr", i), apsr, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_model("rst_first", 32'h0000_0040, 32'h0000_0002, 4'h0, 8'h26);

        run_dir("u_a0a_add", 32'h0A, 32'h02, 4'h0, 8'h26, 32'h0000_000C, 32'h0);
        run_dir("u_a0a_sub", 32'h0A, 32'h02, 4'h1, 8'h26, 32'h0000_0008, 32'h2000_0000);
        run_dir("u_a0a_and", 32'h0A, 32'h02, 4'h2, 8'h26, 32'h0000_0002, 32'h0);
        run_dir("u_a0a_or",  32'h0A, 32'h02, 4'h3, 8'h26, 32'h0000_000A, 32'h0);
        run_dir("l_a0a_add", 32'h0A, 32'h02, 4'h0, 8'h06, 32'h2020_202C, 32'h0);
        run_dir("l_a0a_sub", 32'h0A, 32'h02, 4'h1, 8'h06, 32'h2020_2028, 32'h0);
        run_dir("l_a0a_and", 32'h0A, 32'h02, 4'h2, 8'h06, 32'h2020_2022, 32'h0);
        run_dir("l_a0a_or",  32'h0A, 32'h02, 4'h3, 8'h06, 32'h2020_202A, 32'h0);
        run_dir("u_a21_add", 32'h21, 32'h05, 4'h0, 8'h26, 32'h0000_0026, 32'h0);
        run_dir("u_a21_sub", 32'h21, 32'h05, 4'h1, 8'h26, 32'h0000_001C, 32'h2000_0000);
        run_dir("u_a21_and", 32'h21, 32'h05, 4'h2, 8'h26, 32'h0000_0001, 32'h0);
        run_dir("u_a21_or",  32'h21, 32'h05, 4'h3, 8'h26, 32'h0000_0025, 32'h0);
        run_dir("l_a21_add", 32'h21, 32'h05, 4'h0, 8'h06, 32'h2020_2006, 32'h0);
        run_dir("l_a21_sub", 32'h21, 32'h05, 4'h1, 8'h06, 32'h2020_203C, 32'h0);
        run_dir("l_a21_and", 32'h21, 32'h05, 4'h2, 8'h06, 32'h2020_2021, 32'h0);
        run_dir("l_a21_or",  32'h21, 32'h05, 4'h3, 8'h06, 32'h2020_2005, 32'h0);

        run_dir("add_ovf",   32'h7FFF_FFFF, 32'h1, 4'h0, 8'h26, 32'h8000_0000, 32'h9000_0000);
        run_dir("add_wrap",  32'hFFFF_FFFF, 32'h1, 4'h0, 8'h26, 32'h0,         32'h6000_0000);
        run_dir("sub_zero",  32'h5,         32'h5, 4'h1, 8'h26, 32'h0,         32'h6000_0000);
        run_dir("sub_borrow",32'h0,         32'h1, 4'h1, 8'h26, 32'hFFFF_FFFF, 32'h8000_0000);
        run_dir("rsb",       32'h1,         32'h3, 4'hE, 8'h26, 32'h2,         32'h2000_0000);
        run_dir("lsl_c",     32'h8000_0001, 32'h1, 4'h7, 8'h26, 32'h2,         32'h2000_0000);
        run_dir("lsl_zero",  32'h8000_0000, 32'h0, 4'h7, 8'h26, 32'h8000_0000, 32'h8000_0000);
        run_dir("lsr_hib",   32'h10,  32'hFFFF_FFE1, 4'h8, 8'h26, 32'h8,        32'h0);
        run_dir("asr_neg",   32'h8000_0000, 32'h4, 4'h9, 8'h26, 32'hF800_0000, 32'h8000_0000);
        run_dir("ror_1",     32'h1,         32'h1, 4'hA, 8'h26, 32'h8000_0000, 32'hA000_0000);
        run_dir("slt",       32'hFFFF_FFFF, 32'h1, 4'hB, 8'h26, 32'h1,         32'h0);
        run_dir("sltu",      32'hFFFF_FFFF, 32'h1, 4'hC, 8'h26, 32'h0,         32'h4000_0000);
        run_dir("not",       32'h0,         32'h0, 4'h6, 8'h26, 32'hFFFF_FFFF, 32'h8000_0000);
        run_dir("nor",       32'h0,         32'h0, 4'h5, 8'h26, 32'hFFFF_FFFF, 32'h8000_0000);
        run_dir("l_mov_z",   32'h0, 32'h2020_2020, 4'hD, 8'h06, 32'h0,         32'h4000_0000);
        run_dir("l_add_cv",  32'h7FFF_FFFF, 32'h1, 4'h0, 8'h27, 32'h8101_0101, 32'h8000_0000);

        for (int i = 0; i < 300; i++) begin
            rk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h26;
            run_model($sformatf("rnd%0d", i), $urandom, $urandom, 4'($urandom_range(0, 15)), rk);
        end

        // Reset asserted between edges must clear outputs without waiting for a clock.
        drive(32'h7FFF_FFFF, 32'h1, 4'h0, 8'h26);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", alu_out, 32'h0);
        check("midrst_apsr", apsr, 32'h0);
        @(posedge clk);
        #1;
        check("midrst_hold_out", alu_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_model("midrst_first", 32'hFFFF_FFFF, 32'h1, 4'h0, 8'h26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
